// File: rtl/arbitro_rr_4a1.sv
// arbitro_rr_4a1: round-robin merge of four show-ahead source FIFOs onto one
// downstream FIFO. Each source is served for a burst of up to BURST words.
// One idle arbitration cycle is spent between consecutive grants.
module arbitro_rr_4a1 #(
  parameter int DATA_WIDTH = 12,
  parameter int BURST      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            empty,
  input  logic [DATA_WIDTH-1:0] fifo_out0,
  input  logic [DATA_WIDTH-1:0] fifo_out1,
  input  logic [DATA_WIDTH-1:0] fifo_out2,
  input  logic [DATA_WIDTH-1:0] fifo_out3,
  input  logic                  almost_full,
  output logic [3:0]            pop,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            grant,
  output logic                  busy
);

  typedef enum logic {IDLE, SERVE} state_t;

  localparam logic [2:0] BURST_L = 3'(BURST);

  state_t                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [2:0]            burst_cnt_q, burst_cnt_d;
  logic                  push_q, push_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  logic [DATA_WIDTH-1:0] head_word;
  logic [1:0]            next_src;
  logic                  src_found;
  logic                  pop_any;
  logic                  last_word;

  // Head word of the currently granted source.
  always_comb begin
    head_word = fifo_out0;
    case (grant_q)
      2'd0: head_word = fifo_out0;
      2'd1: head_word = fifo_out1;
      2'd2: head_word = fifo_out2;
      2'd3: head_word = fifo_out3;
      default: head_word = fifo_out0;
    endcase
  end

  // Round-robin scan starting just after the last grant; the last grant itself is checked last.
  always_comb begin
    logic [1:0] cand;
    next_src  = grant_q;
    src_found = 1'b0;
    cand      = grant_q;
    for (int k = 1; k <= 4; k++) begin
      cand = grant_q + 2'(k);
      if (!src_found && !empty[cand]) begin
        next_src  = cand;
        src_found = 1'b1;
      end
    end
  end

  // Pop only the granted source, only in SERVE, never into backpressure or past the burst limit.
  always_comb begin
    pop = 4'b0000;
    if (!reset && state_q == SERVE) begin
      pop[grant_q] = !empty[grant_q] && !almost_full && (burst_cnt_q < BURST_L);
    end
  end

  assign pop_any   = |pop;
  assign last_word = pop_any && ((burst_cnt_q + 3'd1) == BURST_L);

  // Next-state logic: arbitrate in IDLE, release on drained source or completed burst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!almost_full && src_found) state_d = SERVE;
      end
      SERVE: begin
        if ((empty[grant_q] && !pop_any) || last_word) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant pointer, burst counter and registered push/data for the downstream FIFO.
  always_comb begin
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    push_d      = 1'b0;
    data_out_d  = data_out_q;
    if (state_q == IDLE && !almost_full && src_found) begin
      grant_d     = next_src;
      burst_cnt_d = 3'd0;
    end
    if (pop_any) begin
      push_d     = 1'b1;
      data_out_d = head_word;
      if (burst_cnt_q < BURST_L) burst_cnt_d = burst_cnt_q + 3'd1;
    end
  end

  // State and datapath registers with synchronous reset; a reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 2'd3;
      burst_cnt_q <= 3'd0;
      push_q      <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      push_q      <= push_d;
      data_out_q  <= data_out_d;
    end
  end

  assign push     = push_q;
  assign data_out = data_out_q;
  assign grant    = grant_q;
  assign busy     = (state_q == SERVE);

endmodule

// File: tb/tb_arbitro_rr_4a1.sv
// tb_arbitro_rr_4a1: source FIFOs modelled as queues, downstream pushes and
// grant order checked against scoreboards filled when stimulus is loaded.
module tb_arbitro_rr_4a1;

  localparam int DW    = 12;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    empty;
  logic [DW-1:0] fifo_out0, fifo_out1, fifo_out2, fifo_out3;
  logic          almost_full;
  logic [3:0]    pop;
  logic          push;
  logic [DW-1:0] data_out;
  logic [1:0]    grant;
  logic          busy;

  always #5 clk = ~clk;

  arbitro_rr_4a1 #(.DATA_WIDTH(DW), .BURST(BURST)) dut (
    .clk(clk), .reset(reset), .empty(empty),
    .fifo_out0(fifo_out0), .fifo_out1(fifo_out1),
    .fifo_out2(fifo_out2), .fifo_out3(fifo_out3),
    .almost_full(almost_full), .pop(pop), .push(push),
    .data_out(data_out), .grant(grant), .busy(busy)
  );

  typedef struct packed {
    logic [15:0] nwords;
    logic [7:0]  order;
    logic [2:0]  norder;
    logic [3:0]  popmask;
  } vec_t;

  vec_t          vecs [5];
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] src_q [4][$];
  logic [DW-1:0] exp_data [$];
  logic [1:0]    exp_grants [$];
  logic [3:0]    pop_s, pop_or;
  logic          push_s, busy_s;
  logic [DW-1:0] data_s;
  logic [1:0]    grant_s;
  logic          prev_busy = 1'b0;
  int            cyc = 0;
  int            push_num = 0;
  int            first_push_cyc = 0;
  int            p16_cyc = 0;
  int            rem [4];
  int            widx [4];
  int            nstep;

  // Compare one value and report on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Present queue heads and empty flags to the DUT.
  task automatic applyStimulus();
    for (int i = 0; i < 4; i++) empty[i] = (src_q[i].size() == 0);
    fifo_out0 = (src_q[0].size() != 0) ? src_q[0][0] : '0;
    fifo_out1 = (src_q[1].size() != 0) ? src_q[1][0] : '0;
    fifo_out2 = (src_q[2].size() != 0) ? src_q[2][0] : '0;
    fifo_out3 = (src_q[3].size() != 0) ? src_q[3][0] : '0;
  endtask

  // One clock: sample and check at negedge, then apply pops to the source queues after posedge.
  task automatic tick();
    @(negedge clk);
    pop_s   = pop;
    push_s  = push;
    data_s  = data_out;
    grant_s = grant;
    busy_s  = busy;
    pop_or  = pop_or | pop_s;
    checkOutput("pop_onehot", 32'($countones(pop_s) <= 1), 32'd1);
    if (pop_s != 4'b0000)
      checkOutput("pop_legal", 32'(((pop_s & empty) == 4'b0000) && !almost_full), 32'd1);
    if (busy_s === 1'b1 && !prev_busy) begin
      if (exp_grants.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL grant_order: got unexpected grant %0d expected none", grant_s);
      end else begin
        checkOutput("grant_order", 32'(grant_s), 32'(exp_grants.pop_front()));
      end
    end
    prev_busy = (busy_s === 1'b1);
    if (push_s === 1'b1) begin
      push_num++;
      if (push_num == 1) first_push_cyc = cyc;
      if (push_num == 16) p16_cyc = cyc;
      if (exp_data.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL push_data: got unexpected push %0h expected none", data_s);
      end else begin
        checkOutput("push_data", 32'(data_s), 32'(exp_data.pop_front()));
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (pop_s[i] === 1'b1 && src_q[i].size() != 0) void'(src_q[i].pop_front());
    applyStimulus();
  endtask

  // Clock until all expected pushes are seen and the arbiter is idle again.
  task automatic runUntilDone(input string name, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((exp_data.size() != 0 || busy_s !== 1'b0) && n < budget);
    checkOutput({name, "_done"}, 32'(n < budget), 32'd1);
    checkOutput({name, "_grants_left"}, 32'(exp_grants.size()), 32'd0);
    exp_data.delete();
    exp_grants.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{nwords: 16'h1000, order: 8'h03, norder: 3'd1, popmask: 4'b1000};
    vecs[1] = '{nwords: 16'h0505, order: 8'h88, norder: 3'd4, popmask: 4'b0101};
    vecs[2] = '{nwords: 16'h1111, order: 8'h93, norder: 3'd4, popmask: 4'b1111};
    vecs[3] = '{nwords: 16'h0110, order: 8'h09, norder: 3'd2, popmask: 4'b0110};
    vecs[4] = '{nwords: 16'h0700, order: 8'h0A, norder: 3'd2, popmask: 4'b0100};

    reset = 1'b1;
    almost_full = 1'b0;
    pop_or = 4'b0000;

    // T1 reset with all sources full, T2 round robin follows on release.
    for (int k = 0; k < 5; k++) src_q[0].push_back(12'h296);
    for (int k = 0; k < 4; k++) begin
      src_q[1].push_back(12'h196);
      src_q[2].push_back(12'h425);
      src_q[3].push_back(12'h824);
    end
    applyStimulus();
    tick();
    tick();
    checkOutput("rst_pop", 32'(pop_s), 32'd0);
    checkOutput("rst_push", 32'(push_s), 32'd0);
    checkOutput("rst_data", 32'(data_s), 32'd0);
    checkOutput("rst_grant", 32'(grant_s), 32'd3);
    checkOutput("rst_busy", 32'(busy_s), 32'd0);
    reset = 1'b0;
    exp_grants = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 4; k++) exp_data.push_back(12'h296);
    for (int k = 0; k < 4; k++) exp_data.push_back(12'h196);
    for (int k = 0; k < 4; k++) exp_data.push_back(12'h425);
    for (int k = 0; k < 4; k++) exp_data.push_back(12'h824);
    exp_data.push_back(12'h296);
    runUntilDone("t2", 100);
    checkOutput("t2_burst_spacing", 32'(p16_cyc - first_push_cyc), 32'd18);
    checkOutput("t2_final_grant", 32'(grant_s), 32'd0);

    // T3 early release: source 1 holds only two words.
    src_q[1].push_back(12'hA01);
    src_q[1].push_back(12'hA02);
    exp_grants.push_back(2'd1);
    exp_data = '{12'hA01, 12'hA02};
    applyStimulus();
    runUntilDone("t3", 30);
    checkOutput("t3_grant_kept", 32'(grant_s), 32'd1);
    src_q[0].push_back(12'h0B0);
    src_q[3].push_back(12'h3B0);
    exp_grants = '{2'd3, 2'd0};
    exp_data = '{12'h3B0, 12'h0B0};
    applyStimulus();
    runUntilDone("t3b", 30);

    // T4 backpressure after two words of a four-word burst.
    for (int k = 1; k <= 4; k++) begin
      src_q[1].push_back(12'h4A0 + 12'(k));
      exp_data.push_back(12'h4A0 + 12'(k));
    end
    exp_grants.push_back(2'd1);
    applyStimulus();
    nstep = 0;
    while (src_q[1].size() > 2 && nstep < 30) begin
      tick();
      nstep++;
    end
    checkOutput("t4_reach", 32'(nstep < 30), 32'd1);
    almost_full = 1'b1;
    tick();
    checkOutput("t4_stall1_pop", 32'(pop_s), 32'd0);
    checkOutput("t4_stall1_push", 32'(push_s), 32'd1);
    tick();
    checkOutput("t4_stall2_pop", 32'(pop_s), 32'd0);
    checkOutput("t4_stall2_push", 32'(push_s), 32'd0);
    tick();
    checkOutput("t4_stall3_pop", 32'(pop_s), 32'd0);
    checkOutput("t4_stall3_push", 32'(push_s), 32'd0);
    checkOutput("t4_stall_grant", 32'(grant_s), 32'd1);
    checkOutput("t4_stall_busy", 32'(busy_s), 32'd1);
    almost_full = 1'b0;
    tick();
    checkOutput("t4_resume_pop", 32'(pop_s), 32'b0010);
    runUntilDone("t4", 30);

    // T5 reset mid-burst after the first word has been popped.
    src_q[2] = '{12'hEA5, 12'hEA6, 12'hEA7};
    exp_grants.push_back(2'd2);
    exp_data.push_back(12'hEA5);
    applyStimulus();
    nstep = 0;
    while (src_q[2].size() > 2 && nstep < 30) begin
      tick();
      nstep++;
    end
    checkOutput("t5_reach", 32'(nstep < 30), 32'd1);
    reset = 1'b1;
    src_q[0].push_back(12'hC01);
    applyStimulus();
    tick();
    tick();
    checkOutput("t5_rst_pop", 32'(pop_s), 32'd0);
    checkOutput("t5_rst_push", 32'(push_s), 32'd0);
    checkOutput("t5_rst_data", 32'(data_s), 32'd0);
    checkOutput("t5_rst_grant", 32'(grant_s), 32'd3);
    checkOutput("t5_rst_busy", 32'(busy_s), 32'd0);
    reset = 1'b0;
    exp_grants = '{2'd0, 2'd2};
    exp_data = '{12'hC01, 12'hEA6, 12'hEA7};
    runUntilDone("t5", 40);

    // T6 and further patterns: table of source loads with the expected grant order.
    for (int e = 0; e < 5; e++) begin
      for (int s = 0; s < 4; s++) begin
        rem[s]  = int'(vecs[e].nwords[4*s +: 4]);
        widx[s] = 0;
        for (int k = 0; k < rem[s]; k++) src_q[s].push_back({4'(e), 2'(s), 6'(k)});
      end
      for (int j = 0; j < int'(vecs[e].norder); j++) begin
        logic [1:0] g;
        g = vecs[e].order[2*j +: 2];
        exp_grants.push_back(g);
        for (int k = 0; k < BURST && rem[g] > 0; k++) begin
          exp_data.push_back({4'(e), g, 6'(widx[g])});
          widx[g]++;
          rem[g]--;
        end
      end
      pop_or = 4'b0000;
      applyStimulus();
      runUntilDone($sformatf("vec%0d", e), 120);
      checkOutput($sformatf("vec%0d_popmask", e), 32'(pop_or), 32'(vecs[e].popmask));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
